// File: rtl/pong_game_ctrl_if.sv
// Pong controller bus: pixel position and buttons in, object coordinates, scores and state out.
interface pong_game_ctrl_if;
  logic [9:0] x;
  logic [8:0] y;
  logic       btn_l_up, btn_l_dn, btn_r_up, btn_r_dn, btn_start;
  logic       frame_tick;
  logic [9:0] ball_x;
  logic [8:0] ball_y, pad_l_y, pad_r_y;
  logic [3:0] score_l, score_r;
  logic [2:0] game_state;

  modport master (
    output x, y, btn_l_up, btn_l_dn, btn_r_up, btn_r_dn, btn_start,
    input  frame_tick, ball_x, ball_y, pad_l_y, pad_r_y, score_l, score_r, game_state
  );
  modport slave (
    input  x, y, btn_l_up, btn_l_dn, btn_r_up, btn_r_dn, btn_start,
    output frame_tick, ball_x, ball_y, pad_l_y, pad_r_y, score_l, score_r, game_state
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game controller: one update per frame at the start of vertical blanking.
// Define PONG_AI_RIGHT_EN to let the right paddle track the ball instead of btn_r_*.
module pong_game_ctrl #(
  parameter int BALL_SIZE   = 8,
  parameter int PAD_W       = 8,
  parameter int PAD_H       = 64,
  parameter int PAD_L_X     = 16,
  parameter int PAD_R_X     = 616,
  parameter int PAD_SPEED   = 4,
  parameter int BALL_SPEED  = 2,
  parameter int SERVE_DELAY = 60,
  parameter int WIN_SCORE   = 7
) (
  input  logic            clk,
  input  logic            rst,
  pong_game_ctrl_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam int CNT_W = $clog2(SERVE_DELAY);

  localparam logic [9:0] BALL_X0  = 10'((640 - BALL_SIZE) / 2);
  localparam logic [8:0] BALL_Y0  = 9'((480 - BALL_SIZE) / 2);
  localparam logic [8:0] PAD_Y0   = 9'((480 - PAD_H) / 2);
  localparam logic [8:0] PAD_MAX  = 9'(480 - PAD_H);
  localparam logic [9:0] BX_MAX   = 10'(640 - BALL_SIZE);
  localparam logic [8:0] BY_MAX   = 9'(480 - BALL_SIZE);
  localparam logic [9:0] BX_L_HIT = 10'(PAD_L_X + PAD_W);
  localparam logic [9:0] BX_R_HIT = 10'(PAD_R_X - BALL_SIZE);

  localparam logic signed [10:0] SX_L    = 11'(PAD_L_X);
  localparam logic signed [10:0] SX_L_IN = 11'(PAD_L_X + PAD_W);
  localparam logic signed [10:0] SX_R    = 11'(PAD_R_X);
  localparam logic signed [10:0] SX_R_IN = 11'(PAD_R_X + PAD_W);
  localparam logic signed [10:0] SBS     = 11'(BALL_SIZE);
  localparam logic signed [10:0] SSPD    = 11'(BALL_SPEED);
  localparam logic signed [10:0] SX_MAX  = 11'(640 - BALL_SIZE);
  localparam logic signed [10:0] SY_MAX  = 11'(480 - BALL_SIZE);

  // Update slot: rising edge of the registered "first pixel of line 480" condition.
  logic [1:0] tick_pipe;
  logic       frame_tick;
  assign frame_tick = tick_pipe[0] & ~tick_pipe[1];

  logic [2:0]       state_q, state_n;
  logic [9:0]       ball_x_q, ball_x_n;
  logic [8:0]       ball_y_q, ball_y_n;
  logic [8:0]       pad_l_q, pad_l_n, pad_r_q, pad_r_n;
  logic [3:0]       score_l_q, score_l_n, score_r_q, score_r_n;
  logic [CNT_W-1:0] serve_cnt_q, serve_cnt_n;
  logic             dx_neg_q, dx_neg_n, dy_neg_q, dy_neg_n;
  logic             serve_left_q, serve_left_n;

  logic signed [10:0] nx, ny;
  logic               l_ovl, r_ovl, hit_l, hit_r;
  logic               r_up, r_dn;

  function automatic logic [8:0] pad_step(input logic [8:0] p, input logic up, input logic dn);
    pad_step = p;
    if (up && !dn)
      pad_step = (p < 9'(PAD_SPEED)) ? 9'd0 : p - 9'(PAD_SPEED);
    else if (dn && !up)
      pad_step = (p > PAD_MAX - 9'(PAD_SPEED)) ? PAD_MAX : p + 9'(PAD_SPEED);
  endfunction

`ifdef PONG_AI_RIGHT_EN
  logic [9:0] ball_c, pad_c;
  logic       unused_btn_r;
  assign ball_c       = {1'b0, ball_y_q} + 10'(BALL_SIZE / 2);
  assign pad_c        = {1'b0, pad_r_q} + 10'(PAD_H / 2);
  // A +/-2 px dead band keeps the paddle from dithering around the ball centre.
  assign r_up         = (ball_c + 10'd2) < pad_c;
  assign r_dn         = ball_c > (pad_c + 10'd2);
  assign unused_btn_r = bus.btn_r_up ^ bus.btn_r_dn;
`else
  assign r_up = bus.btn_r_up;
  assign r_dn = bus.btn_r_dn;
`endif

  assign nx = $signed({1'b0, ball_x_q}) + (dx_neg_q ? -SSPD : SSPD);
  assign ny = $signed({2'b00, ball_y_q}) + (dy_neg_q ? -SSPD : SSPD);

  // Paddle overlap uses the ball row before this tick's vertical move.
  assign l_ovl = ({1'b0, ball_y_q} + 10'(BALL_SIZE) > {1'b0, pad_l_q}) &&
                 ({1'b0, ball_y_q} < {1'b0, pad_l_q} + 10'(PAD_H));
  assign r_ovl = ({1'b0, ball_y_q} + 10'(BALL_SIZE) > {1'b0, pad_r_q}) &&
                 ({1'b0, ball_y_q} < {1'b0, pad_r_q} + 10'(PAD_H));
  assign hit_l = dx_neg_q && (nx <= SX_L_IN) && (nx + SBS > SX_L) && l_ovl;
  assign hit_r = !dx_neg_q && (nx + SBS >= SX_R) && (nx < SX_R_IN) && r_ovl;

  always_comb begin
    state_n      = state_q;
    ball_x_n     = ball_x_q;
    ball_y_n     = ball_y_q;
    pad_l_n      = pad_l_q;
    pad_r_n      = pad_r_q;
    score_l_n    = score_l_q;
    score_r_n    = score_r_q;
    serve_cnt_n  = serve_cnt_q;
    dx_neg_n     = dx_neg_q;
    dy_neg_n     = dy_neg_q;
    serve_left_n = serve_left_q;

    if (state_q == S_SERVE || state_q == S_PLAY) begin
      pad_l_n = pad_step(pad_l_q, bus.btn_l_up, bus.btn_l_dn);
      pad_r_n = pad_step(pad_r_q, r_up, r_dn);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.btn_start) begin
          state_n  = S_SERVE;
          ball_x_n = BALL_X0;
          ball_y_n = BALL_Y0;
        end
      end
      S_SERVE: begin
        ball_x_n = BALL_X0;
        ball_y_n = BALL_Y0;
        dx_neg_n = serve_left_q;
        dy_neg_n = 1'b0;
        if (serve_cnt_q == CNT_W'(SERVE_DELAY - 1)) begin
          state_n     = S_PLAY;
          serve_cnt_n = '0;
        end else begin
          serve_cnt_n = serve_cnt_q + 1'b1;
        end
      end
      S_PLAY: begin
        if (ny < 11'sd0) begin
          ball_y_n = 9'd0;
          dy_neg_n = 1'b0;
        end else if (ny > SY_MAX) begin
          ball_y_n = BY_MAX;
          dy_neg_n = 1'b1;
        end else begin
          ball_y_n = ny[8:0];
        end
        // Paddle returns win over a miss decided on the same tick.
        if (hit_l) begin
          ball_x_n = BX_L_HIT;
          dx_neg_n = 1'b0;
        end else if (hit_r) begin
          ball_x_n = BX_R_HIT;
          dx_neg_n = 1'b1;
        end else if (nx < 11'sd0) begin
          ball_x_n     = 10'd0;
          score_r_n    = score_r_q + 4'd1;
          serve_left_n = 1'b1;
          state_n      = S_POINT;
        end else if (nx > SX_MAX) begin
          ball_x_n     = BX_MAX;
          score_l_n    = score_l_q + 4'd1;
          serve_left_n = 1'b0;
          state_n      = S_POINT;
        end else begin
          ball_x_n = nx[9:0];
        end
      end
      S_POINT: begin
        if (score_l_q == 4'(WIN_SCORE) || score_r_q == 4'(WIN_SCORE)) begin
          state_n = S_OVER;
        end else begin
          state_n  = S_SERVE;
          ball_x_n = BALL_X0;
          ball_y_n = BALL_Y0;
        end
      end
      S_OVER: begin
        if (bus.btn_start) begin
          state_n   = S_SERVE;
          score_l_n = 4'd0;
          score_r_n = 4'd0;
          ball_x_n  = BALL_X0;
          ball_y_n  = BALL_Y0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_pipe    <= '0;
      state_q      <= S_IDLE;
      ball_x_q     <= BALL_X0;
      ball_y_q     <= BALL_Y0;
      pad_l_q      <= PAD_Y0;
      pad_r_q      <= PAD_Y0;
      score_l_q    <= 4'd0;
      score_r_q    <= 4'd0;
      serve_cnt_q  <= '0;
      dx_neg_q     <= 1'b0;
      dy_neg_q     <= 1'b0;
      serve_left_q <= 1'b0;
    end else begin
      tick_pipe <= {tick_pipe[0], (bus.x == 10'd0) && (bus.y == 9'd480)};
      if (frame_tick) begin
        state_q      <= state_n;
        ball_x_q     <= ball_x_n;
        ball_y_q     <= ball_y_n;
        pad_l_q      <= pad_l_n;
        pad_r_q      <= pad_r_n;
        score_l_q    <= score_l_n;
        score_r_q    <= score_r_n;
        serve_cnt_q  <= serve_cnt_n;
        dx_neg_q     <= dx_neg_n;
        dy_neg_q     <= dy_neg_n;
        serve_left_q <= serve_left_n;
      end
    end
  end

  assign bus.frame_tick = frame_tick;
  assign bus.ball_x     = ball_x_q;
  assign bus.ball_y     = ball_y_q;
  assign bus.pad_l_y    = pad_l_q;
  assign bus.pad_r_y    = pad_r_q;
  assign bus.score_l    = score_l_q;
  assign bus.score_r    = score_r_q;
  assign bus.game_state = state_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomized frame-level bench for pong_game_ctrl against an integer game model.
module tb_pong_game_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pong_game_ctrl_if bus();
  pong_game_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  localparam int IDLE = 0, SERVE = 1, PLAY = 2, POINT = 3, OVER = 4;

  int checks = 0, failures = 0, ticks = 0;
  int m_st, m_bx, m_by, m_dx, m_dy, m_pl, m_pr, m_sl, m_sr, m_cnt, m_srv;
  bit reset_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = IDLE; m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
    m_pl = 208; m_pr = 208; m_sl = 0; m_sr = 0; m_cnt = 0; m_srv = 1;
  endtask

  function automatic int pad_move(input int p, input bit up, input bit dn);
    if (up && !dn) return (p - 4 < 0) ? 0 : p - 4;
    if (dn && !up) return (p + 4 > 416) ? 416 : p + 4;
    return p;
  endfunction

  task automatic model_tick(input bit lu, input bit ld, input bit ru, input bit rd, input bit st);
    int nx, ny, oby, opl, opr;
    oby = m_by; opl = m_pl; opr = m_pr;
    if (m_st == SERVE || m_st == PLAY) begin
      m_pl = pad_move(opl, lu, ld);
`ifdef PONG_AI_RIGHT_EN
      m_pr = pad_move(opr, (oby + 4) < (opr + 30), (oby + 4) > (opr + 34));
`else
      m_pr = pad_move(opr, ru, rd);
`endif
    end
    case (m_st)
      IDLE: if (st) begin m_st = SERVE; m_bx = 316; m_by = 236; end
      SERVE: begin
        m_bx = 316; m_by = 236; m_dx = m_srv; m_dy = 1;
        if (m_cnt == 59) begin m_st = PLAY; m_cnt = 0; end
        else m_cnt++;
      end
      PLAY: begin
        nx = m_bx + 2 * m_dx;
        ny = m_by + 2 * m_dy;
        if (ny < 0) begin m_by = 0; m_dy = 1; end
        else if (ny > 472) begin m_by = 472; m_dy = -1; end
        else m_by = ny;
        if (m_dx < 0 && nx <= 24 && nx + 8 > 16 && oby + 8 > opl && oby < opl + 64) begin
          m_bx = 24; m_dx = 1;
        end else if (m_dx > 0 && nx + 8 >= 616 && nx < 624 && oby + 8 > opr && oby < opr + 64) begin
          m_bx = 608; m_dx = -1;
        end else if (nx < 0) begin
          m_bx = 0; m_sr++; m_srv = -1; m_st = POINT;
        end else if (nx > 632) begin
          m_bx = 632; m_sl++; m_srv = 1; m_st = POINT;
        end else m_bx = nx;
      end
      POINT: begin
        if (m_sl == 7 || m_sr == 7) m_st = OVER;
        else begin m_st = SERVE; m_bx = 316; m_by = 236; end
      end
      OVER: if (st) begin m_st = SERVE; m_sl = 0; m_sr = 0; m_bx = 316; m_by = 236; end
      default: m_st = IDLE;
    endcase
  endtask

  task automatic compare_all(input string pfx);
    chk({pfx, ".ball_x"},  32'(bus.ball_x),     32'(m_bx));
    chk({pfx, ".ball_y"},  32'(bus.ball_y),     32'(m_by));
    chk({pfx, ".pad_l_y"}, 32'(bus.pad_l_y),    32'(m_pl));
    chk({pfx, ".pad_r_y"}, 32'(bus.pad_r_y),    32'(m_pr));
    chk({pfx, ".score_l"}, 32'(bus.score_l),    32'(m_sl));
    chk({pfx, ".score_r"}, 32'(bus.score_r),    32'(m_sr));
    chk({pfx, ".state"},   32'(bus.game_state), 32'(m_st));
  endtask

  // One clock: sample the tick pulse, then drive the next pixel position.
  task automatic cyc(input int xv, input int yv);
    @(negedge clk);
    if (bus.frame_tick === 1'b1) ticks++;
    bus.x = 10'(xv);
    bus.y = 9'(yv);
  endtask

  task automatic frame(input bit lu, input bit ld, input bit ru, input bit rd, input bit st,
                       input int hold_max);
    int h;
    ticks = 0;
    cyc($urandom_range(799), $urandom_range(479));
    bus.btn_l_up = lu; bus.btn_l_dn = ld;
    bus.btn_r_up = ru; bus.btn_r_dn = rd;
    bus.btn_start = st;
    cyc(0, $urandom_range(479));
    h = $urandom_range(hold_max, 1);
    repeat (h) cyc(0, 480);
    cyc(1, 480);
    cyc(300, 481);
    cyc(0, 0);
    cyc(0, 0);
    model_tick(lu, ld, ru, rd, st);
    chk("ticks_per_frame", 32'(ticks), 32'd1);
    compare_all("frame");
  endtask

  initial begin
    bit lu, ld, ru, rd, st;
    rst = 1'b1;
    bus.x = '0; bus.y = '0;
    bus.btn_l_up = 1'b0; bus.btn_l_dn = 1'b0;
    bus.btn_r_up = 1'b0; bus.btn_r_dn = 1'b0;
    bus.btn_start = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset.frame_tick", 32'(bus.frame_tick), 32'd0);
    compare_all("reset");
    rst = 1'b0;

    // Start, then paddle hold and saturation in both directions.
    frame(0, 0, 0, 0, 1, 12);
    repeat (10) frame(1, 1, 0, 0, 0, 12);
    chk("both_hold.pad_l_y", 32'(bus.pad_l_y), 32'd208);
    repeat (60) frame(1, 0, 0, 0, 0, 12);
    chk("sat_top.pad_l_y", 32'(bus.pad_l_y), 32'd0);
    repeat (110) frame(0, 1, 0, 0, 0, 12);
    chk("sat_bot.pad_l_y", 32'(bus.pad_l_y), 32'd416);

    // Right paddle mostly parked at the top so the left player racks up points.
    for (int i = 0; i < 4000; i++) begin
      if (i >= 1500 && !reset_done && m_st == PLAY) begin
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midplay_rst.frame_tick", 32'(bus.frame_tick), 32'd0);
        model_reset();
        compare_all("midplay_rst");
        @(negedge clk);
        rst = 1'b0;
        reset_done = 1'b1;
      end
      lu = 1'($urandom_range(1));
      ld = 1'($urandom_range(1));
      ru = ($urandom_range(7) != 0);
      rd = ($urandom_range(7) == 0);
      st = ($urandom_range(3) == 0);
      frame(lu, ld, ru, rd, st, 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Frame-sequenced game controller for the Pong datapath.
- Watches the VGA pixel position, derives one update slot per frame at the start of vertical blanking, and advances the ball, paddles, scores and game state machine once per frame.
- Outputs are object coordinates consumed by the pixel renderer.
- Coordinates are stable throughout the visible area.

Parameters:
- BALL_SIZE, 8: ball edge length, px.
- PAD_W, 8: paddle width, px.
- PAD_H, 64: paddle height, px.
- PAD_L_X, 16: left paddle left edge x.
- PAD_R_X, 616: right paddle left edge x.
- PAD_SPEED, 4: paddle px per frame.
- BALL_SPEED, 2: ball px per frame, each axis.
- SERVE_DELAY, 60: frames held in SERVE before launch.
- WIN_SCORE, 7: score that ends the game.

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  asynchronous, active-high reset
- x  in  10  current pixel x (0-799)
- y  in  9  current pixel y, low 9 bits of line count
- btn_l_up, btn_l_dn, btn_r_up, btn_r_dn  in  1 each  paddle controls, synchronised and debounced upstream, level-sensitive
- btn_start  in  1  start/restart request, level
- frame_tick  out  1  one-clk pulse marking the update slot
- ball_x  out  10  ball left edge
- ball_y  out  9  ball top edge
- pad_l_y, pad_r_y  out  9 each  paddle top edges
- score_l, score_r  out  4 each  scores
- game_state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: ball_x=316, ball_y=236, pad_l_y=pad_r_y=208, scores 0, game_state=IDLE, frame_tick=0, serve counter 0, direction dx=+1, dy=+1.
- frame_tick: rst_cond = (x==0 && y==480). It is registered, and frame_tick is the rising edge of the registered condition. Exactly one pulse per frame regardless of how many clk cycles x/y are held.
- All state and coordinate registers update only in the cycle where frame_tick=1. Results are visible one clk later (latency 1 from the tick).
- Paddles update in SERVE and PLAY only:
  - up alone: y -= PAD_SPEED; dn alone: y += PAD_SPEED; both or neither: hold.
  - Saturate to [0, 480-PAD_H]; no wrap.
- State machine:
  - IDLE: ball centred, paddles held. btn_start=1 at tick -> SERVE.
  - SERVE: ball forced to (316,236). Counter counts ticks; at SERVE_DELAY-1 -> PLAY, counter cleared. dx points toward the player who conceded last (initially right), dy=+1.
  - PLAY: compute next position nx = ball_x ± BALL_SPEED and ny = ball_y ± BALL_SPEED using 11-bit signed intermediates.
    - Walls: ny<0 -> ball_y=0, dy=+1. ny>480-BALL_SIZE -> ball_y=480-BALL_SIZE, dy=-1.
    - Left paddle: dx<0, nx<=PAD_L_X+PAD_W, nx+BALL_SIZE>PAD_L_X, and y-overlap (ball_y+BALL_SIZE>pad_l_y && ball_y<pad_l_y+PAD_H) -> ball_x=PAD_L_X+PAD_W, dx=+1.
    - Right paddle: mirror case, ball_x=PAD_R_X-BALL_SIZE, dx=-1.
    - Miss: nx<0 -> score_r+1, POINT. nx>640-BALL_SIZE -> score_l+1, POINT. Ball x clamped to 0 or 640-BALL_SIZE.
    - A paddle hit takes priority over a miss on the same tick. Wall and paddle reflections may occur on the same tick.
  - POINT: one tick. If either score==WIN_SCORE -> OVER, else SERVE.
  - OVER: everything frozen. btn_start at tick -> scores cleared, SERVE.
- Scores are 4-bit and never exceed WIN_SCORE (at most 15).
- rst mid-frame or mid-play: immediate return to reset values; a pending tick is lost.

Optional Feature:
- Macro: PONG_AI_RIGHT_EN.
- Defined: right paddle ignores btn_r_*. Each tick in SERVE/PLAY it moves PAD_SPEED toward the ball: up if ball_y+BALL_SIZE/2 < pad_r_y+PAD_H/2-2, down if > centre+2, else hold. Same saturation rules.
- Undefined: right paddle is button-driven and btn_r_* are used as specified.

Test Plan:
- y held at 480 with x=0 for 12 clk, then x increments -> exactly one frame_tick pulse; none while y<480.
- Assert rst during PLAY with ball at (100,50) -> same cycle ball_x=316, ball_y=236, game_state=0, scores 0.
- PLAY, ball_y=1, dy=-1, tick -> ball_y=0, dy=+1; next tick ball_y=2.
- PLAY, pad_l_y=200, ball (26,220), dx=-1, tick -> ball_x=24, dx=+1; with pad_l_y=0 instead -> miss path, score_r 0->1, state POINT then SERVE; launch after 60 ticks toward left.
- btn_l_up and btn_l_dn both held 10 ticks at pad_l_y=208 -> unchanged. btn_l_up held 60 ticks -> saturates at 0. btn_l_dn held -> saturates at 416.
- score_l=6 and right miss -> score_l=7, POINT, OVER. btn_start -> scores 0, SERVE.
